fetch_sequencer: RTL and testbench

- Sequences instruction fetch for the 9-bit core: owns the program counter, runs the Start/Done handshake and stretches multi-cycle instructions flagged by the decoder's stall output.
- Gates datapath commits so that register/memory writes happen once, on the final cycle of each instruction.
- Resolves taken branches through a jump-target lookup table indexed by the decoder's Jptr field.
- Sits between the instruction ROM (drives its address) and the decoder/datapath (consumes stall, Jen, Jptr, Done).

---
 rtl/core_pkg.sv | 20 ++
 rtl/jump_lut.sv | 16 +
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 9-bit core: sequencer states,
// default fetch geometry and decoder constants.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    STALL,
    HALT
  } seq_state_t;

  localparam int PC_W_D       = 10;
  localparam int LUT_AW_D     = 6;
  localparam int START_ADDR_D = 0;
  localparam int CNT_W_D      = 16;

  localparam logic [8:0] OP_HALT = 9'h1FF;

endpackage

// File: rtl/jump_lut.sv
// Branch target ROM. The image is produced from the program's
// memory file at build time and handed in as INIT.
module jump_lut
  import core_pkg::*;
#(
  parameter int PC_W   = PC_W_D,
  parameter int LUT_AW = LUT_AW_D,
  parameter logic [(2**LUT_AW)*PC_W-1:0] INIT = '0
) (
  input  logic [LUT_AW-1:0] i_addr,
  output logic [PC_W-1:0]   o_target
);

  assign o_target = INIT[int'(i_addr)*PC_W +: PC_W];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC owner, Start/Done handshake, stall
// stretching, commit gating and LUT-based branch resolution.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter int PC_W       = PC_W_D,
  parameter int LUT_AW     = LUT_AW_D,
  parameter int START_ADDR = START_ADDR_D,
  parameter int CNT_W      = CNT_W_D,
  parameter logic [(2**LUT_AW)*PC_W-1:0] LUT_INIT = '0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             StallIn,
  input  logic             JenIn,
  input  logic [7:0]       Jptr,
  input  logic             BranchTaken,
  input  logic             DoneIn,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             CommitEn,
  output logic             Phase,
  output logic             Busy,
  output logic             Finished,
  output logic [CNT_W-1:0] CycleCnt
);

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [PC_W-1:0]  w_target;
  logic             r_fin;
  logic             w_fin_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_commit;
  logic             w_busy;

  jump_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW),
    .INIT   (LUT_INIT)
  ) u_lut (
    .i_addr   (Jptr[LUT_AW-1:0]),
    .o_target (w_target)
  );

  generate
    if (LUT_AW < 8) begin : g_jptr_hi
      logic w_unused_jptr;
      assign w_unused_jptr = ^Jptr[7:LUT_AW];
    end
  endgenerate

  always_comb begin
    w_next    = r_state;
    w_pc_nxt  = r_pc;
    w_fin_nxt = r_fin;
    w_load    = 1'b0;
    w_commit  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Start) begin
          w_next = ARMED;
          w_load = 1'b1;
        end
      end
      ARMED: begin
        if (Start) w_load = 1'b1;
        else       w_next = RUN;
      end
      RUN: begin
        if (Start) begin
          w_next = ARMED;
          w_load = 1'b1;
        end else if (DoneIn) begin
          w_next    = HALT;
          w_fin_nxt = 1'b1;
        end else if (StallIn) begin
          w_next = STALL;
        end else begin
          w_commit = 1'b1;
          w_pc_nxt = (JenIn && BranchTaken) ? w_target
                                            : r_pc + 1'b1;
        end
      end
      STALL: begin
        // restart during the second cycle drops its commit
        if (Start) begin
          w_next = ARMED;
          w_load = 1'b1;
        end else begin
          w_next   = RUN;
          w_commit = 1'b1;
          w_pc_nxt = r_pc + 1'b1;
        end
      end
      HALT: begin
        if (Start) begin
          w_next = ARMED;
          w_load = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_load) begin
      w_pc_nxt  = START_PC;
      w_fin_nxt = 1'b0;
    end
  end

  assign w_busy = (r_state == RUN) || (r_state == STALL);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_load)
      w_cnt_nxt = '0;
    else if (w_busy && (r_cnt != CNT_MAX))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_pc    <= START_PC;
      r_fin   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_nxt;
      r_fin   <= w_fin_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign ProgCtr  = r_pc;
  assign CommitEn = w_commit;
  assign Phase    = (r_state == STALL);
  assign Busy     = w_busy;
  assign Finished = r_fin;
  assign CycleCnt = r_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed rows push
// expectations, a negedge monitor pops and compares.
module tb_fetch_sequencer;

  localparam int PC_W = 10;
  localparam int AW   = 6;

  function automatic logic [(2**AW)*PC_W-1:0] mk_lut();
    logic [(2**AW)*PC_W-1:0] r;
    r = '0;
    r[3*PC_W +: PC_W] = 10'd20;
    r[5*PC_W +: PC_W] = 10'd1023;
    return r;
  endfunction

  localparam logic [(2**AW)*PC_W-1:0] TB_LUT = mk_lut();

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       jen = 1'b0;
  logic [7:0] jptr = 8'h00;
  logic       bt = 1'b0;
  logic       done = 1'b0;

  logic [9:0]  pc, pc4;
  logic        ce, ce4, ph, ph4, bz, bz4, fn, fn4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  fetch_sequencer #(.LUT_INIT(TB_LUT)) u_dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start),
    .StallIn(stall), .JenIn(jen), .Jptr(jptr),
    .BranchTaken(bt), .DoneIn(done),
    .ProgCtr(pc), .CommitEn(ce), .Phase(ph),
    .Busy(bz), .Finished(fn), .CycleCnt(cnt)
  );

  fetch_sequencer #(.CNT_W(4), .LUT_INIT(TB_LUT)) u_dut4 (
    .Clk(clk), .Reset_n(rst_n), .Start(start),
    .StallIn(stall), .JenIn(jen), .Jptr(jptr),
    .BranchTaken(bt), .DoneIn(done),
    .ProgCtr(pc4), .CommitEn(ce4), .Phase(ph4),
    .Busy(bz4), .Finished(fn4), .CycleCnt(cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int pc, ce, ph, bz, fn, cnt, cnt4;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   row = 0;

  task automatic chk(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("r%0d.pc", e.id), int'(pc), e.pc);
      chk($sformatf("r%0d.commit", e.id), int'(ce), e.ce);
      chk($sformatf("r%0d.phase", e.id), int'(ph), e.ph);
      chk($sformatf("r%0d.busy", e.id), int'(bz), e.bz);
      chk($sformatf("r%0d.fin", e.id), int'(fn), e.fn);
      chk($sformatf("r%0d.cnt", e.id), int'(cnt), e.cnt);
      chk($sformatf("r%0d.pc4", e.id), int'(pc4), e.pc);
      chk($sformatf("r%0d.cnt4", e.id), int'(cnt4), e.cnt4);
    end
  end

  task automatic vec(input int s, st, j, p, b, d,
                     input int epc, ece, eph, ebz, efn,
                     input int ecnt, ecnt4);
    exp_t e;
    @(posedge clk);
    #1;
    start = s[0]; stall = st[0]; jen = j[0];
    jptr = 8'(p); bt = b[0]; done = d[0];
    row++;
    e.id = row; e.pc = epc; e.ce = ece; e.ph = eph;
    e.bz = ebz; e.fn = efn; e.cnt = ecnt; e.cnt4 = ecnt4;
    sb.push_back(e);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".pc"}, int'(pc), 0);
    chk({tag, ".busy"}, int'(bz), 0);
    chk({tag, ".fin"}, int'(fn), 0);
    chk({tag, ".cnt"}, int'(cnt), 0);
    chk({tag, ".commit"}, int'(ce), 0);
    chk({tag, ".cnt4"}, int'(cnt4), 0);
  endtask

  initial begin
    #2;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    //  S St J  P     B D   pc  ce ph bz fn cnt c4
    vec(1, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0,  0);
    vec(1, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0,  0);
    vec(1, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0,  0);
    vec(0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0,  0);
    vec(0, 0, 0, 0,    0, 0, 0,    1, 0, 1, 0, 0,  0);
    vec(0, 0, 0, 0,    0, 0, 1,    1, 0, 1, 0, 1,  1);
    vec(0, 0, 0, 0,    0, 0, 2,    1, 0, 1, 0, 2,  2);
    vec(0, 0, 0, 0,    0, 0, 3,    1, 0, 1, 0, 3,  3);
    vec(0, 1, 0, 0,    0, 0, 4,    0, 0, 1, 0, 4,  4);
    vec(0, 0, 1, 0,    1, 1, 4,    1, 1, 1, 0, 5,  5);
    vec(0, 0, 0, 0,    0, 0, 5,    1, 0, 1, 0, 6,  6);
    vec(0, 0, 0, 0,    0, 0, 6,    1, 0, 1, 0, 7,  7);
    vec(0, 0, 1, 3,    1, 0, 7,    1, 0, 1, 0, 8,  8);
    vec(0, 0, 1, 3,    0, 0, 20,   1, 0, 1, 0, 9,  9);
    vec(0, 0, 1, 'hC3, 1, 0, 21,   1, 0, 1, 0, 10, 10);
    vec(0, 0, 1, 5,    1, 0, 20,   1, 0, 1, 0, 11, 11);
    vec(0, 0, 0, 0,    0, 0, 1023, 1, 0, 1, 0, 12, 12);
    vec(0, 0, 0, 0,    0, 0, 0,    1, 0, 1, 0, 13, 13);
    vec(0, 0, 0, 0,    0, 1, 1,    0, 0, 1, 0, 14, 14);
    vec(0, 0, 0, 0,    0, 0, 1,    0, 0, 0, 1, 15, 15);
    vec(0, 1, 1, 3,    1, 1, 1,    0, 0, 0, 1, 15, 15);
    vec(1, 0, 0, 0,    0, 0, 1,    0, 0, 0, 1, 15, 15);
    vec(0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0,  0);
    vec(0, 0, 0, 0,    0, 0, 0,    1, 0, 1, 0, 0,  0);
    vec(0, 1, 0, 0,    0, 0, 1,    0, 0, 1, 0, 1,  1);
    vec(1, 0, 0, 0,    0, 0, 1,    0, 1, 1, 0, 2,  2);
    vec(0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0,  0);
    vec(0, 0, 0, 0,    0, 0, 0,    1, 0, 1, 0, 0,  0);

    // mid-run asynchronous reset, checked before any edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      vec(0, 0, 0, 0, 0, 0, i, 1, 0, 1, 0, i,
          (i > 15) ? 15 : i);
    vec(0, 0, 0, 0, 0, 1, 20, 0, 0, 1, 0, 20, 15);
    vec(0, 0, 0, 0, 0, 0, 20, 0, 0, 0, 1, 21, 15);

    @(posedge clk);
    #1;
    start = 0; stall = 0; jen = 0; bt = 0; done = 0;
    for (int k = 0; k < 10 && sb.size() > 0; k++)
      @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
